// File: rtl/spi_dummy_pkg.sv
// spi_dummy_pkg: shared widths, frame geometry, state encoding and reset values
package spi_dummy_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int FRAME_BITS = 24;
  localparam int CMD_BITS = 8;
  localparam logic [DATA_W-1:0] ID_DEFAULT = 16'h5A01;
  localparam logic [DATA_W-1:0] RST_BASE = 16'hA500;
  localparam logic [ADDR_W-1:0] WRCNT_ADDR = 7'h7F;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  function automatic logic [DATA_W-1:0] reg_reset(input int i);
    return RST_BASE + DATA_W'(i);
  endfunction
endpackage

// File: rtl/spi_dummy_if.sv
// spi_dummy_if: write-report and frame-error outputs of the register slave
interface spi_dummy_if;
  import spi_dummy_pkg::*;
  logic wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic frame_err;
  modport master (input wr_strobe, wr_addr, wr_data, frame_err);
  modport slave (output wr_strobe, wr_addr, wr_data, frame_err);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer with rise/fall pulses in the clk domain
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  // two sync stages plus one history stage for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= {3{RST_VAL}};
    else s <= {s[1:0], din};
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_dummy_reg_slave.sv
// spi_dummy_reg_slave: SPI mode-0 half-duplex register slave; SPI_DUMMY_WRCNT_EN adds a write counter at 0x7F
module spi_dummy_reg_slave
  import spi_dummy_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = ID_DEFAULT
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic SPI_CS,
  input  logic SPI_SCK,
  inout  wire  SPI_D,
  spi_dummy_if.slave bus
);
  localparam int IW = $clog2(NUM_REGS);
  state_t state, state_n;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [1:0] d_s;
  logic [4:0] cnt, cnt_n;
  logic [14:0] sr;
  logic rw, d_oe, take, cmd_done, last, wr_n, err_n;
  logic [ADDR_W-1:0] addr, cmd_addr;
  logic [DATA_W-1:0] rd, rd_val, wr_val;
  logic [DATA_W-1:0] regs [NUM_REGS];
`ifdef SPI_DUMMY_WRCNT_EN
  logic [DATA_W-1:0] wrcnt;
`endif
  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.clk(ACLK), .rst(ARESET), .din(SPI_SCK), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(ACLK), .rst(ARESET), .din(SPI_CS), .rise(cs_rise), .fall(cs_fall));
  // raw CS gates the driver so the line is released as soon as the master deselects
  assign SPI_D = (d_oe && !SPI_CS) ? rd[15] : 1'bz;
  // data line synchronized with the same latency as SCK so each rise sees its own bit
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) d_s <= '0;
    else d_s <= {d_s[0], SPI_D};
  // bit acceptance, frame decisions and next state; a CS rise in the same cycle as the last bit still counts it
  always_comb begin
    take = sck_rise && (state == CMD || state == DATA);
    cnt_n = cnt + {4'd0, take};
    cmd_done = take && cnt == 5'(CMD_BITS - 1);
    last = take && cnt == 5'(FRAME_BITS - 1);
    cmd_addr = {sr[5:0], d_s[1]};
    wr_val = {sr[14:0], d_s[1]};
    wr_n = last && !rw && addr != '0 && int'(addr) < NUM_REGS;
    err_n = cs_rise && state != IDLE && cnt_n != '0 && cnt_n < 5'(FRAME_BITS);
    state_n = cs_fall ? CMD : cs_rise ? IDLE : last ? DONE : cmd_done ? DATA : state;
  end
  // read value for the address completed by the command byte
  always_comb begin
    rd_val = cmd_addr == '0 ? ID_VALUE : int'(cmd_addr) < NUM_REGS ? regs[cmd_addr[IW-1:0]] : '0;
`ifdef SPI_DUMMY_WRCNT_EN
    if (cmd_addr == WRCNT_ADDR) rd_val = wrcnt;
`endif
  end
  // frame state register
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) state <= IDLE;
    else state <= state_n;
  // shift-in, read shift-out, register file and report outputs
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      cnt <= '0;
      sr <= '0;
      rw <= 1'b0;
      addr <= '0;
      rd <= '0;
      d_oe <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_reset(i);
`ifdef SPI_DUMMY_WRCNT_EN
      wrcnt <= '0;
`endif
    end else begin
      bus.wr_strobe <= wr_n;
      bus.frame_err <= err_n;
      d_oe <= state_n == DATA && rw && (d_oe || sck_fall);
      if (cs_fall) begin
        cnt <= '0;
        sr <= '0;
      end else if (take) begin
        cnt <= cnt_n;
        sr <= {sr[13:0], d_s[1]};
      end
      if (cmd_done) begin
        rw <= sr[6];
        addr <= cmd_addr;
        rd <= rd_val;
      end else if (d_oe && sck_fall) rd <= {rd[14:0], 1'b0};
      if (wr_n) begin
        regs[addr[IW-1:0]] <= wr_val;
        bus.wr_addr <= addr;
        bus.wr_data <= wr_val;
`ifdef SPI_DUMMY_WRCNT_EN
        wrcnt <= wrcnt + 1'b1;
`endif
      end
    end
endmodule

// File: tb/tb_spi_dummy_reg_slave.sv
// tb_spi_dummy_reg_slave: randomized SPI frames checked against a register-map model
module tb_spi_dummy_reg_slave;
  typedef struct {logic [6:0] a; logic [15:0] d;} wr_t;
  logic clk = 0, arst = 1, spi_cs = 1, spi_sck = 0, m_oe = 0, m_d = 0;
  wire spi_d;
  int tests = 0, fails = 0, n_err = 0, exp_err = 0, mwrcnt = 0;
  logic [15:0] mregs [128];
  wr_t exp_q[$];
  wr_t mon_e;
  spi_dummy_if bus_if();
  assign spi_d = m_oe ? m_d : 1'bz;
  spi_dummy_reg_slave dut (.ACLK(clk), .ARESET(arst), .SPI_CS(spi_cs), .SPI_SCK(spi_sck), .SPI_D(spi_d), .bus(bus_if));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mregs[i] = 16'hA500 + 16'(i);
    mwrcnt = 0;
    exp_q.delete();
  endtask

  function automatic logic [15:0] mread(input int a);
    if (a == 0) return 16'h5A01;
`ifdef SPI_DUMMY_WRCNT_EN
    if (a == 127) return 16'(mwrcnt);
`endif
    if (a < 16) return mregs[a];
    return 16'h0000;
  endfunction

  always @(negedge clk)
    if (!arst) begin
      if (bus_if.wr_strobe) begin
        chk("strobe_queue", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(bus_if.wr_addr), 32'(mon_e.a));
          chk("wr_data", 32'(bus_if.wr_data), 32'(mon_e.d));
        end
      end
      if (bus_if.frame_err) n_err++;
      if (m_oe) chk("contention", 32'(dut.d_oe), 0);
    end

  task automatic frame(input int nbits, input bit rd, input int a, input logic [15:0] wd,
                       input bit cs_with_last, output logic [15:0] got);
    logic [23:0] w;
    w = {rd, 7'(a), wd};
    got = '0;
    if (nbits > 0 && nbits < 24) exp_err++;
    if (nbits >= 24 && !rd && a >= 1 && a < 16) begin
      mregs[a] = wd;
      mwrcnt++;
      exp_q.push_back('{7'(a), wd});
    end
    spi_cs = 0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      m_oe = (i < 8) || !rd;
      m_d = i < 24 ? w[23 - i] : 1'($urandom);
      #50 spi_sck = 1;
      if (cs_with_last && i == nbits - 1) spi_cs = 1;
      if (i >= 8 && i < 24) got = {got[14:0], spi_d};
      #50 spi_sck = 0;
    end
    m_oe = 0;
    #50 spi_cs = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("strobe_done", 32'(exp_q.size()), 0);
    chk("frame_err_cnt", 32'(n_err), 32'(exp_err));
    chk("oe_released", 32'(dut.d_oe), 0);
    if (rd && nbits >= 24) chk($sformatf("read_%02h", a), 32'(got), 32'(mread(a)));
  endtask

  initial begin
    logic [15:0] got;
    logic [23:0] w;
    int a, nb;
    bit r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_strobe", 32'(bus_if.wr_strobe), 0);
    chk("rst_wr_addr", 32'(bus_if.wr_addr), 0);
    chk("rst_wr_data", 32'(bus_if.wr_data), 0);
    chk("rst_frame_err", 32'(bus_if.frame_err), 0);
    chk("rst_oe", 32'(dut.d_oe), 0);
    @(negedge clk) arst = 0;
    repeat (4) @(posedge clk);
    frame(24, 1, 0, 16'h0, 0, got);
    chk("id_read", 32'(got), 32'h5A01);
    frame(24, 0, 0, 16'hFFFF, 0, got);
    frame(24, 1, 0, 16'h0, 0, got);
    chk("id_after_write", 32'(got), 32'h5A01);
    frame(24, 1, 5, 16'h0, 0, got);
    chk("reg5_reset", 32'(got), 32'hA505);
    frame(24, 1, 32, 16'h0, 0, got);
    chk("unimpl_read", 32'(got), 32'h0000);
    frame(24, 0, 3, 16'h1234, 0, got);
    chk("last_wr_addr", 32'(bus_if.wr_addr), 3);
    chk("last_wr_data", 32'(bus_if.wr_data), 32'h1234);
    frame(24, 1, 3, 16'h0, 0, got);
    chk("reg3_written", 32'(got), 32'h1234);
    frame(12, 0, 2, 16'h7777, 0, got);
    chk("partial_err", 32'(n_err), 1);
    frame(24, 1, 2, 16'h0, 0, got);
    chk("reg2_kept", 32'(got), 32'hA502);
    frame(24, 0, 4, 16'hBEEF, 1, got);
    frame(24, 1, 4, 16'h0, 0, got);
    chk("cs_with_last", 32'(got), 32'hBEEF);
    frame(30, 0, 6, 16'h0F0F, 0, got);
    frame(24, 1, 6, 16'h0, 0, got);
    chk("extra_bits", 32'(got), 32'h0F0F);
    frame(24, 1, 127, 16'h0, 0, got);
`ifdef SPI_DUMMY_WRCNT_EN
    chk("wrcnt_read", 32'(got), 32'h0003);
`else
    chk("wrcnt_read", 32'(got), 32'h0000);
`endif
    w = {1'b1, 7'd3, 16'd0};
    spi_cs = 0;
    #100;
    for (int i = 0; i < 12; i++) begin
      m_oe = i < 8;
      m_d = w[23 - i];
      #50 spi_sck = 1;
      #50 spi_sck = 0;
    end
    m_oe = 0;
    #20;
    chk("oe_mid_read", 32'(dut.d_oe), 1);
    arst = 1;
    #1;
    chk("oe_async_rst", 32'(dut.d_oe), 0);
    chk("rst_wr_addr2", 32'(bus_if.wr_addr), 0);
    chk("rst_wr_data2", 32'(bus_if.wr_data), 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) arst = 0;
    spi_cs = 1;
    repeat (8) @(posedge clk);
    frame(24, 1, 3, 16'h0, 0, got);
    chk("reg3_after_rst", 32'(got), 32'hA503);
    frame(24, 1, 6, 16'h0, 0, got);
    chk("reg6_after_rst", 32'(got), 32'hA506);
    for (int k = 0; k < 40; k++) begin
      r = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 127 : int'($urandom_range(0, 20));
      case ($urandom_range(0, 5))
        0: nb = $urandom_range(0, 23);
        1: nb = $urandom_range(25, 30);
        default: nb = 24;
      endcase
      frame(nb, r, a, 16'($urandom), 0, got);
    end
    for (int k = 0; k < 17; k++) frame(24, 1, k, 16'h0, 0, got);
    frame(24, 1, 127, 16'h0, 0, got);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_dummy_reg_slave.md
SPI_DUMMY_REG_SLAVE -- requirements
Module: spi_dummy_reg_slave

Interface
REQ-001 Parameter NUM_REGS, default 16; number of implemented 16-bit registers at addresses 0..NUM_REGS-1.
REQ-002 Parameter ID_VALUE, default 16'h5A01; read-only content of address 0.
REQ-003 ACLK  in  1  single system clock; all logic on rising edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 SPI_CS  in  1  active-low chip select from master.
REQ-006 SPI_SCK  in  1  SPI clock from master (mode 0), asynchronous to ACLK.
REQ-007 SPI_D  inout  1  bidirectional half-duplex data line; slave drives only during the read data phase, otherwise high-Z.
REQ-008 wr_strobe  out  1  one-ACLK pulse per completed register write.
REQ-009 wr_addr  out  7  address of the last completed write.
REQ-010 wr_data  out  16  data of the last completed write.
REQ-011 frame_err  out  1  one-ACLK pulse when CS rises after a partial frame (1..23 bits).

Function
REQ-012 SPI_CS, SPI_SCK and SPI_D input SHALL each pass a 2-FF synchronizer; SCK rise/fall and CS edges are detected in the ACLK domain; ACLK SHALL be at least 8x SCK.
REQ-013 Frame = 24 bits MSB first, sampled on SCK rising edge: bit 0 R/W (1=read), bits 1-7 address, bits 8-23 data.
REQ-014 CS falling edge SHALL clear bit counter and shift register and enter state CMD; states IDLE, CMD (bits 0-7), DATA (bits 8-23), DONE (bits >23, ignored).
REQ-015 Write: on the 24th sampled bit, if address is 1..NUM_REGS-1, register SHALL update and wr_strobe/wr_addr/wr_data SHALL assert 1 ACLK later; address 0 or >= NUM_REGS: no update, no strobe.
REQ-016 Read: after the 8th sampled bit, the addressed value SHALL be loaded; from the next SCK falling edge SPI_D is driven with bit 15, then one bit per falling edge, through bit 0.
REQ-017 Read of address 0 returns ID_VALUE; read of address >= NUM_REGS returns 16'h0000.
REQ-018 SPI_D output enable SHALL drop within 2 ACLK after CS rises, and is never asserted during write frames or the CMD phase.
REQ-019 CS rising before bit 24 SHALL abort the frame: no write, frame_err pulses once; CS rising with 0 bits: no error.
REQ-020 Bits after 24 in the same frame SHALL be ignored; no second write.
REQ-021 Simultaneous CS rise and 24th SCK rise in one ACLK cycle: the bit is counted and the write completes.

Reset
REQ-022 ARESET SHALL immediately set: state IDLE, counters 0, SPI_D high-Z, wr_strobe 0, wr_addr 0, wr_data 0, frame_err 0, register i (i >= 1) = 16'hA500 + i.
REQ-023 Reset mid-frame SHALL discard the frame; the next CS falling edge after release starts a fresh frame.

Configuration
REQ-024 Macro SPI_DUMMY_WRCNT_EN defined: address 7'h7F is a read-only 16-bit count of completed writes (wraps at 16'hFFFF, reset 0); undefined: 7'h7F behaves as any unimplemented address (reads 0).

Structure
REQ-025 Package spi_dummy_pkg SHALL hold ADDR_W=7, DATA_W=16, FRAME_BITS=24, state enum, ID/reset-value constants, WRCNT address.
REQ-026 One sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs, instantiated for SCK and CS.

Verification
REQ-027 Write 0x03 = 16'h1234, then read 0x03 -> wr_strobe once with wr_addr 3, wr_data 16'h1234; read returns 16'h1234.
REQ-028 Read 0x00 after reset -> 16'h5A01; write 0x00 = 16'hFFFF, read again -> 16'h5A01, no wr_strobe.
REQ-029 Read 0x05 after reset -> 16'hA505; read 0x20 -> 16'h0000.
REQ-030 Write 0x02 with CS released after 12 bits -> frame_err pulse, register 2 stays 16'hA502, SPI_D high-Z.
REQ-031 ARESET asserted mid-read -> SPI_D high-Z immediately, all registers back to reset values.
REQ-032 With SPI_DUMMY_WRCNT_EN: three writes then read 0x7F -> 16'h0003; without: read 0x7F -> 16'h0000.
